// File: rtl/fu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fu_pkg
//  Description : Shared constants for the functional-unit writeback path:
//                FU indices, write_sel encoding, default widths and
//                pipeline depth figures.
//  Revision    : 1.0 - initial release
// ============================================================================
package fu_pkg;

  // Default sizing
  localparam int NUM_FU_DEF = 5;
  localparam int XLEN_DEF   = 32;
  localparam int RD_W       = 5;
  localparam int NUM_REGS   = 32;

  // FU indices
  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

  // write_sel: 0 means no writeback, otherwise FU index + 1
  localparam logic [2:0] WSEL_NONE = 3'd0;

  // Pipeline depth: one result slot per FU, then one output register
  localparam int SLOT_DEPTH     = 1;
  localparam int WB_MIN_LATENCY = 2;

  function automatic logic [2:0] wsel_of(input int idx);
    return 3'(idx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches upward from
//                last_grant+1 (wrapping) and returns a one-hot grant.
//                The pointer register is owned by the instantiating block.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fu_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU_DEF,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic w_found;

  // Two passes: first the requesters above the pointer, then the wrap-around
  // part from index 0 up to and including the pointer.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j] && (PTR_W'(j) > last_grant)) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req[j] && (PTR_W'(j) <= last_grant)) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback arbiter. One result slot per FU, round-robin grant
//                of the single register-file write port, registered output
//                stage and a pending-destination mask for hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import fu_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int XLEN   = XLEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FU-1:0]      fu_done,
  input  logic [NUM_FU-1:0]      fu_wen,
  input  logic [NUM_FU*5-1:0]    fu_rd,
  input  logic [NUM_FU*XLEN-1:0] fu_data,
  output logic [NUM_FU-1:0]      fu_ready,
  output logic                   reg_write,
  output logic [4:0]             rd_ctrl,
  output logic [XLEN-1:0]        wb_data,
  output logic [2:0]             write_sel,
  output logic [31:0]            rd_pending
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_slot_valid;
  logic [4:0]        r_slot_rd   [NUM_FU];
  logic [XLEN-1:0]   r_slot_data [NUM_FU];
  logic [PTR_W-1:0]  r_last_grant;

  logic              r_reg_write;
  logic [4:0]        r_rd_ctrl;
  logic [XLEN-1:0]   r_wb_data;
  logic [2:0]        r_write_sel;

  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_load;
  logic [PTR_W-1:0]  w_gidx;
  logic              w_any_grant;
  logic [31:0]       w_pending;

  rr_arbiter #(
    .NUM_REQ (NUM_FU),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req        (r_slot_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // A slot being drained this cycle can take a new result in the same cycle.
  assign fu_ready    = ~r_slot_valid | w_grant;
  assign w_any_grant = |w_grant;

  // Results with no register destination are accepted but never occupy a slot.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_load[i] = fu_done[i] & fu_ready[i] & fu_wen[i] & (|fu_rd[5*i +: 5]);
    end
  end

  // One-hot grant to index for the output mux and the pointer.
  always_comb begin
    w_gidx = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (w_grant[j]) w_gidx = PTR_W'(j);
    end
  end

  // Slot storage: refill takes priority over clear so grant+refill keeps it valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_slot_rd[i]   <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_load[i]) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_rd[i]    <= fu_rd[5*i +: 5];
          r_slot_data[i]  <= fu_data[XLEN*i +: XLEN];
        end else if (w_grant[i]) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage and round-robin pointer; wb_data holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_rd_ctrl    <= '0;
      r_wb_data    <= '0;
      r_write_sel  <= WSEL_NONE;
      r_last_grant <= PTR_W'(NUM_FU - 1);
    end else if (w_any_grant) begin
      r_reg_write  <= 1'b1;
      r_rd_ctrl    <= r_slot_rd[w_gidx];
      r_wb_data    <= r_slot_data[w_gidx];
      r_write_sel  <= wsel_of(int'(w_gidx));
      r_last_grant <= w_gidx;
    end else begin
      r_reg_write  <= 1'b0;
      r_rd_ctrl    <= '0;
      r_write_sel  <= WSEL_NONE;
    end
  end

  // Destinations still owed to the register file: held slots plus output stage.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (r_slot_valid[i]) w_pending[r_slot_rd[i]] = 1'b1;
    end
    if (r_reg_write) w_pending[r_rd_ctrl] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign rd_pending = w_pending;
  assign reg_write  = r_reg_write;
  assign rd_ctrl    = r_rd_ctrl;
  assign wb_data    = r_wb_data;
  assign write_sel  = r_write_sel;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: per-FU request queues
//                drive the FUs, a cycle-level behavioural model predicts the
//                outputs, and directed scenarios pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int NF = 5;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } req_t;

  logic          clk;
  logic          rst;
  logic [NF-1:0] fu_done;
  logic [NF-1:0] fu_wen;
  logic [NF*5-1:0]  fu_rd;
  logic [NF*32-1:0] fu_data;
  logic [NF-1:0] fu_ready;
  logic          reg_write;
  logic [4:0]    rd_ctrl;
  logic [31:0]   wb_data;
  logic [2:0]    write_sel;
  logic [31:0]   rd_pending;

  wb_arbiter #(.NUM_FU(NF), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .fu_done    (fu_done),
    .fu_wen     (fu_wen),
    .fu_rd      (fu_rd),
    .fu_data    (fu_data),
    .fu_ready   (fu_ready),
    .reg_write  (reg_write),
    .rd_ctrl    (rd_ctrl),
    .wb_data    (wb_data),
    .write_sel  (write_sel),
    .rd_pending (rd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 0;

  req_t fq [NF][$];

  // Behavioural model state
  bit          m_valid [NF];
  logic [4:0]  m_rd    [NF];
  logic [31:0] m_data  [NF];
  int          m_last;
  logic        m_rw;
  logic [4:0]  m_rdc;
  logic [2:0]  m_ws;
  logic [31:0] m_wb;

  // Observations of DUT writebacks
  int          wr_cnt [8];
  logic [31:0] mul_log[$];
  int          div_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int m_pick();
    for (int k = 1; k <= NF; k++) begin
      int idx;
      idx = (m_last + k) % NF;
      if (m_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push(input int fu, input logic wen, input logic [4:0] rd, input logic [31:0] d);
    req_t r;
    r.wen = wen; r.rd = rd; r.data = d;
    fq[fu].push_back(r);
  endtask

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      if (fq[i].size() > 0) begin
        fu_done[i]       = 1'b1;
        fu_wen[i]        = fq[i][0].wen;
        fu_rd[5*i +: 5]  = fq[i][0].rd;
        fu_data[32*i +: 32] = fq[i][0].data;
      end else begin
        fu_done[i]       = 1'b0;
        fu_wen[i]        = 1'b0;
        fu_rd[5*i +: 5]  = 5'd0;
        fu_data[32*i +: 32] = 32'd0;
      end
    end
  endtask

  // Advance the model by one clock edge from the inputs presented for it.
  task automatic model_step();
    int g;
    bit rdy [NF];
    cyc++;
    started = 1;
    if (rst) begin
      for (int i = 0; i < NF; i++) begin
        m_valid[i] = 0; m_rd[i] = 0; m_data[i] = 0;
        fq[i].delete();
      end
      m_last = NF - 1;
      m_rw = 0; m_rdc = 0; m_ws = 0; m_wb = 0;
    end else begin
      g = m_pick();
      for (int i = 0; i < NF; i++) rdy[i] = !m_valid[i] || (g == i);
      if (g >= 0) begin
        m_rw = 1; m_rdc = m_rd[g]; m_wb = m_data[g]; m_ws = 3'(g + 1);
        m_valid[g] = 0;
        m_last = g;
      end else begin
        m_rw = 0; m_rdc = 0; m_ws = 0;
      end
      for (int i = 0; i < NF; i++) begin
        if (fu_done[i] && rdy[i]) begin
          if (fu_wen[i] && fu_rd[5*i +: 5] != 5'd0) begin
            m_valid[i] = 1; m_rd[i] = fu_rd[5*i +: 5]; m_data[i] = fu_data[32*i +: 32];
          end
          if (fq[i].size() > 0) void'(fq[i].pop_front());
        end
      end
      // Upstream rule: no two held results target the same register
      for (int i = 0; i < NF; i++)
        for (int j = i + 1; j < NF; j++)
          if (m_valid[i] && m_valid[j] && m_rd[i] == m_rd[j]) begin
            n_chk++; n_fail++;
            $display("FAIL unique_rd: slots %0d and %0d both hold rd %0d", i, j, m_rd[i]);
          end
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the model
  initial begin
    for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        logic [31:0] ep;
        logic [NF-1:0] er;
        int g;
        ep = '0;
        for (int i = 0; i < NF; i++) if (m_valid[i]) ep[m_rd[i]] = 1'b1;
        if (m_rw) ep[m_rdc] = 1'b1;
        ep[0] = 1'b0;
        g = m_pick();
        for (int i = 0; i < NF; i++) er[i] = !m_valid[i] || (g == i);
        chk("m_reg_write",  64'(reg_write),  64'(m_rw));
        chk("m_write_sel",  64'(write_sel),  64'(m_ws));
        chk("m_rd_ctrl",    64'(rd_ctrl),    64'(m_rdc));
        chk("m_wb_data",    64'(wb_data),    64'(m_wb));
        chk("m_fu_ready",   64'(fu_ready),   64'(er));
        chk("m_rd_pending", 64'(rd_pending), 64'(ep));
        if (reg_write === 1'b1) begin
          wr_cnt[write_sel]++;
          if (write_sel == 3'd3) mul_log.push_back(wb_data);
          if (write_sel == 3'd4) div_cyc.push_back(cyc);
        end
      end
    end
  end

  int base_alu, base_div, base_mul, base_mem, t0, nlog, ndiv;

  initial begin
    rst = 1'b1;
    fu_done = '0; fu_wen = '0; fu_rd = '0; fu_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready",     64'(fu_ready),   64'h1f);
    chk("rst_reg_write", 64'(reg_write),  64'h0);
    chk("rst_write_sel", 64'(write_sel),  64'h0);
    chk("rst_pending",   64'(rd_pending), 64'h0);
    chk("rst_wb_data",   64'(wb_data),    64'h0);

    // Single ALU result
    push(0, 1'b1, 5'd5, 32'h1234);
    tick();
    chk("t1_pend_c2", 64'(rd_pending[5]), 64'h1);
    chk("t1_rw_c2",   64'(reg_write),     64'h0);
    tick();
    chk("t1_rw_c3",   64'(reg_write),     64'h1);
    chk("t1_rd_c3",   64'(rd_ctrl),       64'h5);
    chk("t1_data_c3", 64'(wb_data),       64'h1234);
    chk("t1_sel_c3",  64'(write_sel),     64'h1);
    chk("t1_pend_c3", 64'(rd_pending[5]), 64'h1);
    tick();
    chk("t1_rw_c4",   64'(reg_write),     64'h0);
    chk("t1_pend_c4", 64'(rd_pending[5]), 64'h0);

    // All five FUs at once after reset
    do_reset();
    for (int i = 0; i < NF; i++) push(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
    tick();
    chk("t2_ready4_n1", 64'(fu_ready[4]), 64'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t2_sel_seq", 64'(write_sel), 64'(k));
      chk("t2_ready4", 64'(fu_ready[4]), (k + 1 <= 4) ? 64'h0 : 64'h1);
    end
    tick();
    chk("t2_drain_rw", 64'(reg_write), 64'h0);

    // Branch result on JUMP and rd=0 on ALU: accepted, never written
    push(4, 1'b0, 5'd7, 32'hBEEF);
    push(0, 1'b1, 5'd0, 32'hCAFE);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_rw",      64'(reg_write),  64'h0);
      chk("t3_pending", 64'(rd_pending), 64'h0);
      chk("t3_ready",   64'(fu_ready),   64'h1f);
    end

    // ALU streaming 8 results with one DIV result joining
    do_reset();
    base_alu = wr_cnt[1]; base_div = wr_cnt[4]; ndiv = div_cyc.size();
    t0 = cyc;
    for (int k = 0; k < 8; k++) push(0, 1'b1, 5'd8, 32'h100 + 32'(k));
    tick();
    tick();
    push(3, 1'b1, 5'd20, 32'hD1);
    repeat (20) tick();
    chk("t4_alu_writes", 64'(wr_cnt[1] - base_alu), 64'd8);
    chk("t4_div_writes", 64'(wr_cnt[4] - base_div), 64'd1);
    if (div_cyc.size() > ndiv) chk("t4_div_cycle", 64'(div_cyc[ndiv] - t0), 64'd4);
    else chk("t4_div_seen", 64'd0, 64'd1);

    // MUL holds done while its slot is full
    do_reset();
    base_mul = wr_cnt[3]; nlog = mul_log.size();
    push(0, 1'b1, 5'd10, 32'h10);
    push(2, 1'b1, 5'd11, 32'hA);
    push(2, 1'b1, 5'd12, 32'hB);
    tick();
    chk("t5_mul_not_ready", 64'(fu_ready[2]), 64'h0);
    repeat (6) tick();
    chk("t5_mul_writes", 64'(wr_cnt[3] - base_mul), 64'd2);
    if (mul_log.size() >= nlog + 2) begin
      chk("t5_mul_first",  64'(mul_log[nlog]),     64'hA);
      chk("t5_mul_second", 64'(mul_log[nlog + 1]), 64'hB);
    end else chk("t5_mul_log", 64'(mul_log.size() - nlog), 64'd2);

    // Reset with three loaded slots
    do_reset();
    push(0, 1'b1, 5'd13, 32'h13);
    push(1, 1'b1, 5'd14, 32'h14);
    push(2, 1'b1, 5'd15, 32'h15);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rw",      64'(reg_write),  64'h0);
    chk("t6_pending", 64'(rd_pending), 64'h0);
    base_mem = wr_cnt[2];
    push(0, 1'b1, 5'd9, 32'h99);
    tick();
    chk("t6_rw_idle", 64'(reg_write), 64'h0);
    tick();
    chk("t6_rw_alu",   64'(reg_write), 64'h1);
    chk("t6_sel_alu",  64'(write_sel), 64'h1);
    chk("t6_rd_alu",   64'(rd_ctrl),   64'h9);
    chk("t6_data_alu", 64'(wb_data),   64'h99);
    repeat (3) tick();
    chk("t6_no_mem", 64'(wr_cnt[2] - base_mem), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the multi-cycle functional-unit pipeline. Accepts completed results from the five FUs (ALU, MEM, MUL, DIV, JUMP), holds each in a one-entry per-FU result slot, and grants the single register-file write port to one slot per cycle in round-robin order. It also exports a pending-destination mask so the control unit can detect RAW/WAW hazards against results not yet written back.

## Interface
- `NUM_FU`, default 5: number of requesting FUs; index 0..4 = ALU, MEM, MUL, DIV, JUMP.
- `XLEN`, default 32: result data width.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous reset, active-high.
- `fu_done  in  NUM_FU`: per-FU result-valid strobe.
- `fu_wen  in  NUM_FU`: per-FU result writes rd (0 for branches and stores).
- `fu_rd  in  NUM_FU*5`: per-FU destination register, packed with FU i at bits [5i+4:5i].
- `fu_data  in  NUM_FU*XLEN`: per-FU result, packed the same way.
- `fu_ready  out  NUM_FU`: per-FU slot can accept this cycle.
- `reg_write  out  1`: register-file write enable.
- `rd_ctrl  out  5`: write address.
- `wb_data  out  XLEN`: write data.
- `write_sel  out  3`: source FU encoding, FU index+1, with 0 meaning none.
- `rd_pending  out  32`: one-hot OR of destinations held in valid slots or in the output stage; bit 0 is always 0.

## Operation
- Each slot holds valid, rd, and data.
- Capture:
  - A capture occurs when `fu_done[i] & fu_ready[i]`.
  - If `fu_wen[i]==0` or `fu_rd==0`, the result is accepted and discarded; the slot is not set.
  - Otherwise the slot is loaded and becomes valid.
- `fu_ready[i] = ~slot_valid[i] | grant[i]`. A slot granted this cycle refills in the same cycle.
- `fu_done[i]` while `fu_ready[i]==0` is not captured. The FU holds done, rd and data stable until ready; this is a protocol rule and the bench asserts it.
- Arbitration:
  - Round-robin over valid slots, searching upward starting at `last_grant+1` modulo NUM_FU.
  - At most one grant per cycle.
  - `last_grant` updates only when a grant occurs.
- Output stage:
  - This is a register. On a grant it loads `reg_write=1`, `rd_ctrl`, `wb_data` and `write_sel=i+1`, and the granted slot clears.
  - With no grant, `reg_write`, `rd_ctrl` and `write_sel` are 0. `wb_data` holds its previous value.
- `rd_pending`:
  - Combinational from the valid slots plus the output-stage rd while `reg_write=1`.
  - The same-cycle capture is not included.
- Upstream guarantees no two valid slots share an rd. The bench asserts this; behaviour under violation is undefined.
- Reset puts all slots invalid, all outputs 0, `last_grant=NUM_FU-1` (so the ALU wins first), and `fu_ready` all 1 in the cycle after reset deasserts.

## Timing
- Latency:
  - If `fu_done` is high in cycle N and the slot is granted in cycle N+1, `reg_write` is high in cycle N+2.
  - Minimum latency is 2 cycles.
  - Worst case is NUM_FU+1 cycles when all slots are contending.
- Throughput is one writeback per cycle sustained.
- A single FU issuing done every cycle sustains 1/cycle because it is granted every cycle when no other slot is valid.
- Starvation is bounded: a valid slot is granted within NUM_FU cycles.
- Reset asserted mid-operation drops all slot contents and the output stage on that edge, with no partial writeback. `reg_write` is 0 in the following cycle.
- Capture, grant and clear of different slots in the same cycle are independent.
- Grant and refill of the same slot in the same cycle leaves the slot valid with the new data.

## Structure
- Shared package `fu_pkg` holds:
  - FU index constants FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_JUMP=4.
  - The write_sel encoding (index+1, with 0 meaning none).
  - NUM_FU and XLEN defaults.
  - The pipeline depth constants.
- Sub-module `rr_arbiter`: generic NUM_REQ round-robin arbiter.
  - Inputs: `req`, `last_grant`.
  - Output: one-hot `grant`.
  - Purely combinational; the pointer register lives in wb_arbiter.

## Test plan
- Single ALU result: `fu_done[0]`, rd=5, data=0x1234 in cycle 1 -> `reg_write=1`, `rd_ctrl=5`, `wb_data=0x1234`, `write_sel=1` in cycle 3. `rd_pending[5]=1` in cycles 2-3, 0 in cycle 4.
- All five FUs done simultaneously after reset with rd=1..5 -> `write_sel` sequence 1,2,3,4,5 in cycles N+2..N+6. `fu_ready[4]=0` during N+1..N+4.
- `fu_wen=0` (branch result) on JUMP, or rd=0 on ALU -> no `reg_write` and no `rd_pending` bit; `fu_ready` stays 1.
- ALU done every cycle for 8 cycles with DIV done once at cycle 3 -> ALU and DIV alternate while both are valid. The DIV write appears by cycle 6 and no ALU result is lost (8 ALU writes total).
- MUL holds done while not ready (slot full and another slot granted) -> no duplicate capture; data is written exactly once.
- Reset asserted in the cycle after three slots load -> no `reg_write` afterwards, `rd_pending=0`, and the next single ALU result is granted first.
